// File: rtl/fpu_mult_pkg.sv
// Shared constants for the FPU multiplier datapath: rounding modes,
// rounding/normalization FSM encoding and default format widths.
package fpu_mult_pkg;

  localparam int W_SP  = 23;
  localparam int EW_SP = 8;
  localparam int W_DP  = 52;
  localparam int EW_DP = 11;

  localparam logic [1:0] RM_NEAREST_EVEN = 2'b00;
  localparam logic [1:0] RM_TO_ZERO      = 2'b01;
  localparam logic [1:0] RM_TO_POS_INF   = 2'b10;
  localparam logic [1:0] RM_TO_NEG_INF   = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUND = 2'd1;
  localparam logic [1:0] ST_NORM  = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

endpackage

// File: rtl/round_inc_decision.sv
// IEEE-754 round-increment decision from LSB, guard and sticky bits.
// Purely combinational so the adder path can share it.
module round_inc_decision
  import fpu_mult_pkg::*;
(
  input  logic [1:0] r_mode,
  input  logic       sign,
  input  logic       lsb,
  input  logic       guard,
  input  logic       sticky,
  output logic       inc,
  output logic       inexact
);

  always_comb begin
    inexact = guard | sticky;
    case (r_mode)
      RM_NEAREST_EVEN: inc = guard & (sticky | lsb);
      RM_TO_ZERO:      inc = 1'b0;
      RM_TO_POS_INF:   inc = ~sign & (guard | sticky);
      default:         inc = sign & (guard | sticky);
    endcase
  end

endmodule

// File: rtl/mult_round_norm.sv
// Multiplier post-rounding stage: rounds the normalized product, renormalizes
// on carry-out and saturates to infinity on exponent overflow.
module mult_round_norm
  import fpu_mult_pkg::*;
#(
  parameter int W  = W_SP,
  parameter int EW = EW_SP
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic          sign_i,
  input  logic [EW-1:0] exp_i,
  input  logic [W:0]    sgf_i,
  input  logic          guard_i,
  input  logic          round_ok_i,
  input  logic [1:0]    r_mode_i,
  output logic          valid_o,
  input  logic          ready_i,
  output logic          sign_o,
  output logic [EW-1:0] exp_o,
  output logic [W-1:0]  frac_o,
  output logic          overflow_o,
  output logic          inexact_o
);

  logic [1:0]    state_reg, state_next;
  logic          sign_reg;
  logic [EW-1:0] exp_reg;
  logic [W:0]    sgf_reg;
  logic          guard_reg;
  logic          sticky_reg;
  logic [1:0]    rm_reg;
  logic [W+1:0]  sum_reg;
  logic          inexact_reg;

  logic          inc;
  logic          inexact_dec;
  logic          carry;
  logic [EW-1:0] exp_rnd;
  logic [W-1:0]  frac_rnd;
  logic          ovf;

  round_inc_decision u_dec (
    .r_mode  (rm_reg),
    .sign    (sign_reg),
    .lsb     (sgf_reg[0]),
    .guard   (guard_reg),
    .sticky  (sticky_reg),
    .inc     (inc),
    .inexact (inexact_dec)
  );

  assign ready_o = (state_reg == ST_IDLE);
  assign valid_o = (state_reg == ST_OUT);

  // A carry-out means the significand rolled over to 10.000...; its fraction is zero.
  assign carry    = sum_reg[W+1];
  assign exp_rnd  = carry ? exp_reg + {{(EW-1){1'b0}}, 1'b1} : exp_reg;
  assign frac_rnd = carry ? sum_reg[W:1] : sum_reg[W-1:0];
  assign ovf      = (&exp_rnd) | (&exp_reg);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (valid_i) state_next = ST_ROUND;
      ST_ROUND: state_next = ST_NORM;
      ST_NORM:  state_next = ST_OUT;
      default:  if (ready_i) state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      sign_reg    <= 1'b0;
      exp_reg     <= '0;
      sgf_reg     <= '0;
      guard_reg   <= 1'b0;
      sticky_reg  <= 1'b0;
      rm_reg      <= RM_NEAREST_EVEN;
      sum_reg     <= '0;
      inexact_reg <= 1'b0;
      sign_o      <= 1'b0;
      exp_o       <= '0;
      frac_o      <= '0;
      overflow_o  <= 1'b0;
      inexact_o   <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (valid_i) begin
            sign_reg   <= sign_i;
            exp_reg    <= exp_i;
            sgf_reg    <= sgf_i;
            guard_reg  <= guard_i;
            sticky_reg <= round_ok_i;
            rm_reg     <= r_mode_i;
          end
        end
        ST_ROUND: begin
          sum_reg     <= {1'b0, sgf_reg} + {{(W+1){1'b0}}, inc};
          inexact_reg <= inexact_dec;
        end
        ST_NORM: begin
          // Overflow always yields infinity, whatever the rounding mode.
          sign_o     <= sign_reg;
          exp_o      <= ovf ? {EW{1'b1}} : exp_rnd;
          frac_o     <= ovf ? '0 : frac_rnd;
          overflow_o <= ovf;
          inexact_o  <= inexact_reg;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_round_norm.sv
// Directed scoreboard bench for mult_round_norm (single precision).
// Stimulus pushes expected results; a negedge monitor pops and compares on handshake.
module tb_mult_round_norm;

  localparam int W  = 23;
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic          sign_i = 1'b0;
  logic [EW-1:0] exp_i = '0;
  logic [W:0]    sgf_i = '0;
  logic          guard_i = 1'b0;
  logic          round_ok_i = 1'b0;
  logic [1:0]    r_mode_i = 2'b00;
  logic          valid_o;
  logic          ready_i = 1'b1;
  logic          sign_o;
  logic [EW-1:0] exp_o;
  logic [W-1:0]  frac_o;
  logic          overflow_o;
  logic          inexact_o;

  typedef struct {
    logic          sign;
    logic [EW-1:0] exp;
    logic [W-1:0]  frac;
    logic          ovf;
    logic          inx;
  } exp_t;

  exp_t sb_q[$];
  int   acc_q[$];
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   txn = 0;
  logic vprev = 1'b0;

  mult_round_norm #(.W(W), .EW(EW)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .sign_i     (sign_i),
    .exp_i      (exp_i),
    .sgf_i      (sgf_i),
    .guard_i    (guard_i),
    .round_ok_i (round_ok_i),
    .r_mode_i   (r_mode_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .sign_o     (sign_o),
    .exp_o      (exp_o),
    .frac_o     (frac_o),
    .overflow_o (overflow_o),
    .inexact_o  (inexact_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
  endtask

  // Acceptance cycle numbers, for the latency check.
  always @(posedge clk) begin
    if (rst && valid_i && ready_o) acc_q.push_back(cyc);
    cyc++;
  end

  always @(negedge clk) begin
    if (!rst) begin
      vprev = 1'b0;
    end else begin
      if (valid_o && !vprev) begin
        if (acc_q.size() == 0) chk("latency_no_accept", 32'd1, 32'd0);
        else chk("latency", cyc - acc_q.pop_front(), 32'd3);
      end
      if (valid_o && ready_i) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          $display("txn %0d: sign=%0b exp=%h frac=%h ovf=%0b inx=%0b", txn, sign_o, exp_o,
                   frac_o, overflow_o, inexact_o);
          chk("sign", 32'(sign_o), 32'(e.sign));
          chk("exp", 32'(exp_o), 32'(e.exp));
          chk("frac", 32'(frac_o), 32'(e.frac));
          chk("overflow", 32'(overflow_o), 32'(e.ovf));
          chk("inexact", 32'(inexact_o), 32'(e.inx));
          txn++;
        end
      end
      vprev = valid_o;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready_o && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready_o) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic drive(input logic s, input logic [EW-1:0] e, input logic [W:0] g_sgf,
                       input logic gd, input logic st, input logic [1:0] rm);
    sign_i = s; exp_i = e; sgf_i = g_sgf; guard_i = gd; round_ok_i = st; r_mode_i = rm;
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic send(input logic s, input logic [EW-1:0] e, input logic [W:0] g_sgf,
                      input logic gd, input logic st, input logic [1:0] rm,
                      input logic [EW-1:0] xe, input logic [W-1:0] xf,
                      input logic xo, input logic xi);
    wait_ready();
    sb_q.push_back('{sign: s, exp: xe, frac: xf, ovf: xo, inx: xi});
    drive(s, e, g_sgf, gd, st, rm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst = 1'b0;
    #1;
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_exp", 32'(exp_o), 32'd0);
    chk("rst_frac", 32'(frac_o), 32'd0);
    chk("rst_flags", {29'd0, sign_o, overflow_o, inexact_o}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // RNE ties, carry renormalization, overflow, saturated input exponent
    send(0, 8'h80, 24'h800000, 1, 0, 2'b00, 8'h80, 23'h000000, 0, 1);
    send(0, 8'h80, 24'h800001, 1, 0, 2'b00, 8'h80, 23'h000002, 0, 1);
    send(0, 8'h80, 24'hFFFFFF, 1, 1, 2'b00, 8'h81, 23'h000000, 0, 1);
    send(0, 8'hFE, 24'hFFFFFF, 1, 1, 2'b00, 8'hFF, 23'h000000, 1, 1);
    send(0, 8'hFF, 24'h800000, 0, 0, 2'b00, 8'hFF, 23'h000000, 1, 0);
    // Directed modes on a negative operand
    send(1, 8'h80, 24'h800000, 0, 1, 2'b10, 8'h80, 23'h000000, 0, 1);
    send(1, 8'h80, 24'h800000, 0, 1, 2'b01, 8'h80, 23'h000000, 0, 1);
    send(1, 8'h80, 24'h800000, 0, 1, 2'b11, 8'h80, 23'h000001, 0, 1);

    // Backpressure: hold result for 5 clocks while a new operand is offered
    wait_ready();
    ready_i = 1'b0;
    send(0, 8'h40, 24'h800003, 1, 1, 2'b00, 8'h40, 23'h000004, 0, 1);
    for (int n = 0; n < 20 && !valid_o; n++) begin
      @(posedge clk); #1;
    end
    chk("bp_reach_out", 32'(valid_o), 32'd1);
    sign_i = 1'b1; exp_i = 8'h11; sgf_i = 24'hABCDEF; guard_i = 1'b1; valid_i = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(valid_o), 32'd1);
      chk("bp_ready", 32'(ready_o), 32'd0);
      chk("bp_exp", 32'(exp_o), 32'h40);
      chk("bp_frac", 32'(frac_o), 32'h000004);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;

    // Reset abort while the operation sits in ROUND
    wait_ready();
    drive(0, 8'h80, 24'hFFFFFF, 1, 1, 2'b00);
    #2 rst = 1'b0;
    #1;
    chk("abort_ready", 32'(ready_o), 32'd1);
    chk("abort_valid", 32'(valid_o), 32'd0);
    chk("abort_exp", 32'(exp_o), 32'd0);
    chk("abort_frac", 32'(frac_o), 32'd0);
    chk("abort_flags", {29'd0, sign_o, overflow_o, inexact_o}, 32'd0);
    acc_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("post_abort_ready", 32'(ready_o), 32'd1);

    // Recovery after reset: inexact without increment
    send(0, 8'h7F, 24'h9ABCDE, 0, 1, 2'b00, 8'h7F, 23'h1ABCDE, 0, 1);

    for (int n = 0; n < 100 && sb_q.size() != 0; n++) @(posedge clk);
    repeat (2) @(posedge clk);
    chk("drain", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
